controle_jogo_param: RTL

CONTROLE_JOGO_PARAM -- requirements
Module: controle_jogo_param

---
 rtl/jogo_pkg.sv | 21 ++
 rtl/temporizador_jogada.sv | 30 +++
 rtl/controle_jogo_param.sv | 132 +++++++++++++
 3 files changed

// File: rtl/jogo_pkg.sv
// Shared constants for the game controller: state codes and move-timer width.
package jogo_pkg;

    localparam int TIMER_W = 20;

    localparam logic [3:0] INICIAL        = 4'h0;
    localparam logic [3:0] PREPARACAO     = 4'h1;
    localparam logic [3:0] JOGA_MACRO     = 4'h2;
    localparam logic [3:0] REGISTRA_MACRO = 4'h3;
    localparam logic [3:0] JOGA_MICRO     = 4'h4;
    localparam logic [3:0] REGISTRA_MICRO = 4'h5;
    localparam logic [3:0] TROCA          = 4'h6;
    localparam logic [3:0] DECIDE_MACRO   = 4'h7;
    localparam logic [3:0] ESTOURO        = 4'h9;
    localparam logic [3:0] FIM            = 4'hF;

    function automatic logic em_jogada(input logic [3:0] e);
        return (e == JOGA_MACRO) || (e == JOGA_MICRO);
    endfunction

endpackage

// File: rtl/temporizador_jogada.sv
// Per-move timer: counts cycles spent waiting for a move, flags the last one.
module temporizador_jogada
    import jogo_pkg::*;
#(
    parameter int TIMEOUT_CICLOS = 5000
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    localparam logic [TIMER_W-1:0] LIMITE = TIMER_W'(TIMEOUT_CICLOS - 1);

    logic [TIMER_W-1:0] contagem;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            contagem <= '0;
        end else if (clear) begin
            contagem <= '0;
        end else if (enable) begin
            contagem <= contagem + 1'b1;
        end
    end

    assign terminal = enable && (contagem == LIMITE);

endmodule

// File: rtl/controle_jogo_param.sv
// Game-flow controller: macro/micro move sequencing, move timeout, player turn.
module controle_jogo_param
    import jogo_pkg::*;
#(
    parameter int N_JOGADORES    = 2,
    parameter int TIMEOUT_CICLOS = 5000,
    parameter int W_JOG          = $clog2(N_JOGADORES)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             iniciar,
    input  logic             tem_jogada,
    input  logic             jogada_valida,
    input  logic             fim_jogo,
    input  logic             escolhe_macro,
    output logic             zeraR_macro,
    output logic             zeraR_micro,
    output logic             zeraEdge,
    output logic             registraR_macro,
    output logic             registraR_micro,
    output logic             jogar_macro,
    output logic             jogar_micro,
    output logic             pronto,
    output logic             timeout,
    output logic             erro_jogada,
    output logic [W_JOG-1:0] jogador_atual,
    output logic [3:0]       db_estado
);

    localparam logic [W_JOG-1:0] ULTIMO = W_JOG'(N_JOGADORES - 1);

    logic [3:0] estado;
    logic [3:0] estado_nxt;
    logic       aguardando;
    logic       rejeitada;
    logic       terminal;

    assign aguardando = em_jogada(estado);
    assign rejeitada  = aguardando && tem_jogada && !jogada_valida;

    // An invalid move restarts the clock for the same player.
    temporizador_jogada #(
        .TIMEOUT_CICLOS(TIMEOUT_CICLOS)
    ) u_timer (
        .clock   (clock),
        .reset   (reset),
        .clear   (!aguardando || rejeitada),
        .enable  (aguardando),
        .terminal(terminal)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado <= INICIAL;
        end else begin
            estado <= estado_nxt;
        end
    end

    always_comb begin
        estado_nxt = INICIAL;
        case (estado)
            INICIAL:        estado_nxt = iniciar ? PREPARACAO : INICIAL;
            PREPARACAO:     estado_nxt = JOGA_MACRO;
            JOGA_MACRO: begin
                if (tem_jogada) begin
                    estado_nxt = jogada_valida ? REGISTRA_MACRO
                                               : JOGA_MACRO;
                end else if (terminal) begin
                    estado_nxt = ESTOURO;
                end else begin
                    estado_nxt = JOGA_MACRO;
                end
            end
            REGISTRA_MACRO: estado_nxt = JOGA_MICRO;
            JOGA_MICRO: begin
                if (tem_jogada) begin
                    estado_nxt = jogada_valida ? REGISTRA_MICRO
                                               : JOGA_MICRO;
                end else if (terminal) begin
                    estado_nxt = ESTOURO;
                end else begin
                    estado_nxt = JOGA_MICRO;
                end
            end
            REGISTRA_MICRO: estado_nxt = TROCA;
            ESTOURO:        estado_nxt = TROCA;
            TROCA:          estado_nxt = fim_jogo ? FIM : DECIDE_MACRO;
            DECIDE_MACRO: begin
                estado_nxt = escolhe_macro ? PREPARACAO : REGISTRA_MACRO;
            end
            FIM:            estado_nxt = iniciar ? INICIAL : FIM;
            default:        estado_nxt = INICIAL;
        endcase
    end

    // Cleared on the way into INICIAL so it already reads 0 there.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            jogador_atual <= '0;
        end else if (estado_nxt == INICIAL) begin
            jogador_atual <= '0;
        end else if (estado == TROCA) begin
            if (jogador_atual == ULTIMO) begin
                jogador_atual <= '0;
            end else begin
                jogador_atual <= jogador_atual + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            erro_jogada <= 1'b0;
        end else begin
            erro_jogada <= rejeitada;
        end
    end

    assign zeraR_macro     = (estado == INICIAL) || (estado == PREPARACAO);
    assign zeraR_micro     = (estado == INICIAL) || (estado == PREPARACAO)
                          || (estado == DECIDE_MACRO);
    assign zeraEdge        = (estado == INICIAL);
    assign registraR_macro = (estado == REGISTRA_MACRO);
    assign registraR_micro = (estado == REGISTRA_MICRO);
    assign jogar_macro     = (estado == JOGA_MACRO);
    assign jogar_micro     = (estado == JOGA_MICRO);
    assign pronto          = (estado == FIM);
    assign timeout         = (estado == ESTOURO);
    assign db_estado       = estado;

endmodule
